// File: rtl/pipe_hold_ctrl.sv
// ============================================================================
//  Module   : pipe_hold_ctrl
//  Purpose  : Hold/flush scheduler for the if_id/id_ex pipeline registers,
//             PC redirect driver and consecutive-stall timeout monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        hold_bus_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [7:0]  stall_cnt_o,
    output logic        stall_timeout_o
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT  = 8'(STALL_TIMEOUT);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_nxt;
    logic        stall_take;
    logic [7:0]  stall_cnt_inc;

    logic        redirect;
    logic        hold_req;

    // A jump seen during FLUSH comes from a squashed instruction, so only
    // an interrupt may redirect there.
    assign redirect = int_assert_i | (jump_req_i & (state != ST_FLUSH));
    assign hold_req = hold_ex_i | hold_clint_i;

    assign stall_cnt_inc = (stall_cnt_o == 8'hFF) ? 8'hFF : stall_cnt_o + 8'd1;

    always_comb begin
        hold_flag_o   = HOLD_NONE;
        jump_flag_o   = 1'b0;
        jump_addr_o   = 32'd0;
        state_nxt     = ST_RUN;
        flush_cnt_nxt = flush_cnt;
        stall_take    = 1'b0;

        if (redirect) begin
            hold_flag_o   = HOLD_ID;
            jump_flag_o   = 1'b1;
            jump_addr_o   = int_assert_i ? int_addr_i : jump_addr_i;
            state_nxt     = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
            flush_cnt_nxt = FLUSH_RELOAD;
        end else if (state == ST_FLUSH) begin
            hold_flag_o   = HOLD_ID;
            state_nxt     = (flush_cnt == 4'd1) ? ST_RUN : ST_FLUSH;
            flush_cnt_nxt = flush_cnt - 4'd1;
        end else if (hold_req) begin
            hold_flag_o   = HOLD_ID;
            state_nxt     = ST_STALL;
            stall_take    = 1'b1;
        end else if (hold_bus_i) begin
            hold_flag_o   = HOLD_PC;
        end

        // Outputs stay quiet while reset is held, whatever the inputs do.
        if (!rst) begin
            hold_flag_o = HOLD_NONE;
            jump_flag_o = 1'b0;
            jump_addr_o = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_RUN;
            flush_cnt       <= 4'd0;
            stall_cnt_o     <= 8'd0;
            stall_timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (stall_take) begin
                stall_cnt_o <= stall_cnt_inc;
                if (stall_cnt_inc == TIMEOUT_CNT) begin
                    stall_timeout_o <= 1'b1;
                end
            end else begin
                stall_cnt_o <= 8'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hold_ctrl
//  Purpose  : Scoreboard bench for pipe_hold_ctrl (FLUSH_CYCLES=2, STALL_TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        hold_ex_i;
    logic        hold_clint_i;
    logic        hold_bus_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [7:0]  stall_cnt_o;
    logic        stall_timeout_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] addr;
        logic [7:0]  cnt;
        logic        to;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    pipe_hold_ctrl #(
        .FLUSH_CYCLES (2),
        .STALL_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .int_assert_i   (int_assert_i),
        .int_addr_i     (int_addr_i),
        .hold_ex_i      (hold_ex_i),
        .hold_clint_i   (hold_clint_i),
        .hold_bus_i     (hold_bus_i),
        .hold_flag_o    (hold_flag_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .stall_cnt_o    (stall_cnt_o),
        .stall_timeout_o(stall_timeout_o)
    );

    always #5 clk = ~clk;

    // Monitor: compares the DUT against the oldest expectation at mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (hold_flag_o !== e.hold || jump_flag_o !== e.jf || jump_addr_o !== e.addr ||
                stall_cnt_o !== e.cnt || stall_timeout_o !== e.to) begin
                failures++;
                $display("FAIL %s: got hold=%0d jf=%0b addr=%h cnt=%0d to=%0b, want hold=%0d jf=%0b addr=%h cnt=%0d to=%0b",
                         n, hold_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o, stall_timeout_o,
                         e.hold, e.jf, e.addr, e.cnt, e.to);
            end
        end
    end

    // One cycle of stimulus with its hand-computed expected response.
    task automatic step(input string n, input logic r,
                        input logic jr, input logic [31:0] ja,
                        input logic ia, input logic [31:0] iaddr,
                        input logic hex, input logic hcl, input logic hbus,
                        input logic [2:0] eh, input logic ejf, input logic [31:0] ea,
                        input logic [7:0] ec, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        jump_req_i   = jr;
        jump_addr_i  = ja;
        int_assert_i = ia;
        int_addr_i   = iaddr;
        hold_ex_i    = hex;
        hold_clint_i = hcl;
        hold_bus_i   = hbus;
        e.hold = eh; e.jf = ejf; e.addr = ea; e.cnt = ec; e.to = eto;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic idle(input string n, input logic [2:0] eh, input logic [7:0] ec, input logic eto);
        step(n, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, eh, 1'b0, 32'd0, ec, eto);
    endtask

    task automatic stall(input string n, input logic hex, input logic hcl, input logic hbus,
                         input logic [2:0] eh, input logic [7:0] ec, input logic eto);
        step(n, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, hex, hcl, hbus, eh, 1'b0, 32'd0, ec, eto);
    endtask

    task automatic do_reset();
        step("reset_hold", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 8'd0, 1'b0);
        step("reset_hold", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; jump_req_i = 1'b0; jump_addr_i = '0; int_assert_i = 1'b0;
        int_addr_i = '0; hold_ex_i = 1'b0; hold_clint_i = 1'b0; hold_bus_i = 1'b0;
        do_reset();

        for (int i = 0; i < 10; i++) idle("idle_after_reset", 3'd0, 8'd0, 1'b0);

        // single jump, two bubble cycles
        step("jump_c0", 1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h100, 8'd0, 1'b0);
        idle("jump_c1", 3'd3, 8'd0, 1'b0);
        idle("jump_c2", 3'd0, 8'd0, 1'b0);

        // interrupt during FLUSH re-redirects
        step("jmp_then_int_c0", 1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h100, 8'd0, 1'b0);
        step("jmp_then_int_c1", 1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h80, 8'd0, 1'b0);
        idle("jmp_then_int_c2", 3'd3, 8'd0, 1'b0);
        idle("jmp_then_int_c3", 3'd0, 8'd0, 1'b0);

        // jump during FLUSH is ignored
        step("flush_jump_c0", 1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h100, 8'd0, 1'b0);
        step("flush_jump_ignored", 1'b1, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd0, 8'd0, 1'b0);
        idle("flush_jump_c2", 3'd0, 8'd0, 1'b0);

        // simultaneous jump and interrupt: interrupt target wins
        step("jmp_int_same", 1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 32'h80, 8'd0, 1'b0);
        idle("jmp_int_same_c1", 3'd3, 8'd0, 1'b0);
        idle("jmp_int_same_c2", 3'd0, 8'd0, 1'b0);

        // hold_ex for 5 cycles; timeout (4) trips on the 4th count
        for (int i = 0; i < 5; i++)
            stall("hold_ex", 1'b1, 1'b0, 1'b0, 3'd3, 8'(i), (i >= 4) ? 1'b1 : 1'b0);
        idle("hold_ex_exit", 3'd0, 8'd5, 1'b1);
        idle("hold_ex_cleared", 3'd0, 8'd0, 1'b1);
        do_reset();

        // hold_clint for 6 cycles, timeout sticky after release
        for (int i = 0; i < 6; i++)
            stall("hold_clint", 1'b0, 1'b1, 1'b0, 3'd3, 8'(i), (i >= 4) ? 1'b1 : 1'b0);
        idle("clint_exit", 3'd0, 8'd6, 1'b1);
        idle("clint_sticky", 3'd0, 8'd0, 1'b1);
        idle("clint_sticky2", 3'd0, 8'd0, 1'b1);
        do_reset();

        // bus contention alone, and combined with a stall
        stall("bus_only", 1'b0, 1'b0, 1'b1, 3'd1, 8'd0, 1'b0);
        stall("bus_only_again", 1'b0, 1'b0, 1'b1, 3'd1, 8'd0, 1'b0);
        stall("bus_and_ex", 1'b1, 1'b0, 1'b1, 3'd3, 8'd0, 1'b0);
        stall("stall_exit_bus", 1'b0, 1'b0, 1'b1, 3'd1, 8'd1, 1'b0);
        idle("bus_done", 3'd0, 8'd0, 1'b0);

        // redirect while stalled clears the count and flushes
        stall("stall_pre_jump", 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);
        step("jump_in_stall", 1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 32'h40, 8'd1, 1'b0);
        stall("flush_ignores_ex", 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);
        stall("restall_after_flush", 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);
        idle("restall_exit", 3'd0, 8'd1, 1'b0);
        idle("restall_cleared", 3'd0, 8'd0, 1'b0);

        // reset pulse mid-STALL with requests still active
        stall("pre_rst_stall0", 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 1'b0);
        stall("pre_rst_stall1", 1'b1, 1'b0, 1'b0, 3'd3, 8'd1, 1'b0);
        step("rst_mid_stall", 1'b0, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 8'd0, 1'b0);
        idle("after_rst", 3'd0, 8'd0, 1'b0);
        idle("after_rst2", 3'd0, 8'd0, 1'b0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
